// File: rtl/seq_scan_controller.sv
// seq_scan_controller: accepts words over valid/ready, shifts them MSB-first through an
// overlapping 1011 Moore detector and reports the per-word match count over valid/ready.
module seq_scan_controller #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_keep,
    output logic              serial_bit,
    output logic              serial_valid,
    output logic              match_pulse,
    output logic              done_valid,
    output logic [CNT_W-1:0]  done_count,
    input  logic              done_ready,
    output logic              busy
);
    localparam int BW = $clog2(WORD_W);
    localparam logic [BW-1:0] LAST = BW'(WORD_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
    typedef enum logic [2:0] {ZERO, ONE, ONE_ZERO, ONE_ZERO_ONE, ONE_ZERO_ONE_ONE} det_t;

    state_t            state, state_next;
    det_t              det, det_next;
    logic [WORD_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic [CNT_W-1:0]  match_cnt;
    logic              hit;

    always_comb begin
        det_next = ZERO;
        case (det)
            ZERO:             det_next = shreg[WORD_W-1] ? ONE : ZERO;
            ONE:              det_next = shreg[WORD_W-1] ? ONE : ONE_ZERO;
            ONE_ZERO:         det_next = shreg[WORD_W-1] ? ONE_ZERO_ONE : ZERO;
            ONE_ZERO_ONE:     det_next = shreg[WORD_W-1] ? ONE_ZERO_ONE_ONE : ONE_ZERO;
            ONE_ZERO_ONE_ONE: det_next = shreg[WORD_W-1] ? ONE : ONE_ZERO;
            default:          det_next = ZERO;
        endcase
    end

    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        serial_valid = 1'b0;
        done_valid   = 1'b0;
        case (state)
            IDLE: begin
                in_ready   = 1'b1;
                state_next = in_valid ? SHIFT : IDLE;
            end
            SHIFT: begin
                serial_valid = 1'b1;
                state_next   = (bit_cnt == LAST) ? REPORT : SHIFT;
            end
            REPORT: begin
                done_valid = 1'b1;
                state_next = done_ready ? IDLE : REPORT;
            end
            default: state_next = IDLE;
        endcase
    end

    assign hit        = serial_valid && (det_next == ONE_ZERO_ONE_ONE);
    assign serial_bit = serial_valid & shreg[WORD_W-1];
    assign done_count = done_valid ? match_cnt : '0;
    assign busy       = !in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            det         <= ZERO;
            shreg       <= '0;
            bit_cnt     <= '0;
            match_cnt   <= '0;
            match_pulse <= 1'b0;
        end else begin
            state       <= state_next;
            match_pulse <= hit;
            if (in_ready && in_valid) begin
                shreg     <= in_word;
                bit_cnt   <= '0;
                match_cnt <= '0;
                if (!in_keep) det <= ZERO;
            end else if (serial_valid) begin
                det     <= det_next;
                shreg   <= {shreg[WORD_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
                if (hit && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_scan_controller.sv
// tb_seq_scan_controller: directed scenarios for seq_scan_controller with hand-computed
// counts, pulse positions and handshake timing.
module tb_seq_scan_controller;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_word = '0;
    logic        in_keep = 1'b0;
    logic        serial_bit;
    logic        serial_valid;
    logic        match_pulse;
    logic        done_valid;
    logic [4:0]  done_count;
    logic        done_ready = 1'b0;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_n = 0;
    logic [4:0] dq[$];

    seq_scan_controller #(.WORD_W(16), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .in_keep(in_keep), .serial_bit(serial_bit),
        .serial_valid(serial_valid), .match_pulse(match_pulse), .done_valid(done_valid),
        .done_count(done_count), .done_ready(done_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset && in_valid && in_ready) acc_n <= acc_n + 1;
        if (!reset && done_valid && done_ready) dq.push_back(done_count);
    end

    task automatic send(input logic [15:0] w, input logic k);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        total++;
        if (n == 50) begin
            $display("FAIL send_timeout in_ready=%b expected 1", in_ready);
            bad++;
        end
        in_valid = 1'b1; in_word = w; in_keep = k;
        @(posedge clock); #1;
        in_valid = 1'b0; in_word = ~w; in_keep = ~k;
    endtask

    // Returns at #1 after shift edge T16, i.e. inside the first REPORT cycle.
    task automatic run_word(input logic [15:0] w, input logic k, output logic [15:0] p,
                            output int sv_bad);
        send(w, k);
        p = '0;
        sv_bad = 0;
        for (int i = 1; i <= 16; i++) begin
            if (serial_valid !== 1'b1 || done_valid !== 1'b0 || in_ready !== 1'b0 ||
                serial_bit !== w[16-i]) sv_bad++;
            @(posedge clock); #1;
            p[i-1] = match_pulse;
        end
    endtask

    task automatic handshake();
        done_ready = 1'b1;
        @(posedge clock); #1;
        done_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        total += 7;
        if (in_ready !== 1'b1) begin $display("FAIL rst_in_ready got=%b exp=1", in_ready); bad++; end
        if (busy !== 1'b0) begin $display("FAIL rst_busy got=%b exp=0", busy); bad++; end
        if (serial_valid !== 1'b0) begin $display("FAIL rst_serial_valid got=%b exp=0", serial_valid); bad++; end
        if (serial_bit !== 1'b0) begin $display("FAIL rst_serial_bit got=%b exp=0", serial_bit); bad++; end
        if (match_pulse !== 1'b0) begin $display("FAIL rst_match_pulse got=%b exp=0", match_pulse); bad++; end
        if (done_valid !== 1'b0) begin $display("FAIL rst_done_valid got=%b exp=0", done_valid); bad++; end
        if (done_count !== 5'd0) begin $display("FAIL rst_done_count got=%0d exp=0", done_count); bad++; end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_word(input string name, input logic [15:0] w, input logic k,
                             input logic [4:0] exp_cnt, input logic [15:0] exp_p);
        logic [15:0] p;
        int sv_bad;
        done_ready = 1'b0;
        run_word(w, k, p, sv_bad);
        total += 6;
        if (sv_bad !== 0) begin $display("FAIL %s_shift_phase bad_cycles=%0d exp=0", name, sv_bad); bad++; end
        if (done_valid !== 1'b1) begin $display("FAIL %s_done_valid got=%b exp=1", name, done_valid); bad++; end
        if (done_count !== exp_cnt) begin $display("FAIL %s_count got=%0d exp=%0d", name, done_count, exp_cnt); bad++; end
        if (p !== exp_p) begin $display("FAIL %s_pulses got=%h exp=%h", name, p, exp_p); bad++; end
        if (serial_valid !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL %s_report_flags serial_valid=%b busy=%b exp 0,1", name, serial_valid, busy); bad++;
        end
        handshake();
        if (in_ready !== 1'b1 || done_valid !== 1'b0) begin
            $display("FAIL %s_after_hs in_ready=%b done_valid=%b exp 1,0", name, in_ready, done_valid); bad++;
        end
    endtask

    task automatic test_keep();
        test_word("keep_a", 16'h0005, 1'b0, 5'd0, 16'h0000);
        test_word("keep_b", 16'h8000, 1'b1, 5'd1, 16'h0001);
        test_word("nokeep_a", 16'h0005, 1'b0, 5'd0, 16'h0000);
        test_word("nokeep_b", 16'h8000, 1'b0, 5'd0, 16'h0000);
    endtask

    task automatic test_stall();
        logic [15:0] p;
        int sv_bad;
        int acc0;
        done_ready = 1'b0;
        run_word(16'h0000, 1'b0, p, sv_bad);
        acc0 = acc_n;
        in_valid = 1'b1; in_word = 16'hB000; in_keep = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (done_valid !== 1'b1 || done_count !== 5'd0 || in_ready !== 1'b0) begin
                $display("FAIL stall_%0d done_valid=%b count=%0d in_ready=%b exp 1,0,0",
                         i, done_valid, done_count, in_ready);
                bad++;
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        total += 2;
        if (acc_n !== acc0) begin $display("FAIL stall_no_accept got=%0d exp=%0d", acc_n, acc0); bad++; end
        handshake();
        if (in_ready !== 1'b1) begin $display("FAIL stall_ready_after got=%b exp=1", in_ready); bad++; end
    endtask

    task automatic test_reset_mid();
        dq.delete();
        done_ready = 1'b1;
        send(16'hFFFF, 1'b0);
        repeat (7) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        total += 3;
        if (in_ready !== 1'b1 || busy !== 1'b0 || serial_valid !== 1'b0 || serial_bit !== 1'b0) begin
            $display("FAIL mid_rst_ctrl in_ready=%b busy=%b serial_valid=%b serial_bit=%b exp 1,0,0,0",
                     in_ready, busy, serial_valid, serial_bit);
            bad++;
        end
        if (done_valid !== 1'b0 || done_count !== 5'd0 || match_pulse !== 1'b0) begin
            $display("FAIL mid_rst_out done_valid=%b count=%0d pulse=%b exp 0,0,0",
                     done_valid, done_count, match_pulse);
            bad++;
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        if (dq.size() !== 0) begin $display("FAIL mid_rst_no_done got=%0d exp=0", dq.size()); bad++; end
        test_word("after_rst", 16'hB000, 1'b0, 5'd1, 16'h0008);
    endtask

    task automatic test_back_to_back();
        logic [15:0] words[3] = '{16'hB000, 16'h0B00, 16'h00B0};
        int t[3];
        int n;
        dq.delete();
        done_ready = 1'b1;
        in_keep = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_word = words[i];
            n = 0;
            while (in_ready !== 1'b1 && n < 60) begin
                @(posedge clock); #1;
                n++;
            end
            @(posedge clock); #1;
            t[i] = cyc;
        end
        in_valid = 1'b0;
        n = 0;
        while (dq.size() < 3 && n < 60) begin
            @(posedge clock); #1;
            n++;
        end
        total += 3;
        if (dq.size() !== 3) begin
            $display("FAIL b2b_results got=%0d exp=3", dq.size());
            bad++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (dq[i] !== 5'd1) begin $display("FAIL b2b_count_%0d got=%0d exp=1", i, dq[i]); bad++; end
            end
        end
        if (t[1] - t[0] !== 18) begin $display("FAIL b2b_gap0 got=%0d exp=18", t[1] - t[0]); bad++; end
        if (t[2] - t[1] !== 18) begin $display("FAIL b2b_gap1 got=%0d exp=18", t[2] - t[1]); bad++; end
        done_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word("b000", 16'hB000, 1'b0, 5'd1, 16'h0008);
        test_word("b6db", 16'hB6DB, 1'b0, 5'd5, 16'h9248);
        test_keep();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
